pat_code_tx: RTL
================

// Module: pat_code_tx
// PURPOSE
//   Serial transmitter for the 16-bit pat code word. Sends one header byte followed by the
//   code as two 8N1 UART bytes on one line (idle high). Sits on the MCU-link side of the
//   pingpong design, either as the board's code source or as the bench stimulus for the
//   pat receive path. One clock domain, with bit timing from an internal baud counter.
// PARAMETERS
//   CLKS_PER_BIT  5208   clk cycles per serial bit (50 MHz / 9600 baud); must be >= 2
//   HEADER        8'hA5  sync byte sent first in every frame
//   GAP_BITS      1      idle-high bit times inserted between bytes in a frame (0 allowed)
// PORTS
//   clk      in   1   system clock
//   rst_n    in   1   asynchronous active-low reset
//   send     in   1   request: transmit data; sampled only while busy=0
//   data     in   16  code word; latched in the cycle send is accepted
//   tx       out  1   serial line, idle high
//   busy     out  1   high from the cycle after acceptance until the frame completes
//   done     out  1   one-cycle pulse when the final stop bit completes
// BEHAVIOUR
//   Reset: tx=1, busy=0, done=0, state=IDLE, all counters 0. Reset takes effect asynchronously
//     at any point, including mid-frame. The line returns high at once, and a partial frame is
//     abandoned with no done pulse.
//   Frame byte order: HEADER, data[7:0], data[15:8]. Bits go LSB first.
//   Each byte is 1 start bit (0), 8 data bits, then 1 stop bit (1).
//   Every bit is held exactly CLKS_PER_BIT cycles.
//   Acceptance: send=1 in IDLE at edge N latches data into a shift/hold register. At edge N,
//     busy rises and tx drops to 0, both visible in cycle N+1.
//   FSM (all outputs registered):
//     IDLE  -> START on acceptance.
//     START -> DATA after CLKS_PER_BIT cycles.
//     DATA  -> STOP after 8 bit times; the bit index is 0..7.
//     STOP  -> GAP after the stop bit if byte_idx<2 and GAP_BITS>0.
//     STOP  -> START after the stop bit if byte_idx<2 and GAP_BITS=0.
//     STOP  -> IDLE after the stop bit if byte_idx==2.
//     GAP   -> START after GAP_BITS*CLKS_PER_BIT cycles, with tx=1 throughout.
//   byte_idx counts 0..2 and increments on leaving STOP. It does not wrap within a frame
//     and clears in IDLE.
//   Frame length from first start edge to IDLE is (30 + 2*GAP_BITS)*CLKS_PER_BIT cycles.
//   Completion: on the edge ending the last stop bit, the block enters IDLE with busy=0 and
//     done=1 for exactly one cycle.
//   done and send coincide: a send=1 in that same done cycle is accepted, which gives
//     back-to-back frames with no extra idle bit.
//   send while busy=1 is ignored, with no queueing. Changes on data while busy do not affect
//     the frame in flight.
//   send held high continuously makes a new frame start immediately after each done.
//   Counters:
//     Baud counter width is $clog2(CLKS_PER_BIT) bits. It counts 0..CLKS_PER_BIT-1, wraps
//       to 0 and generates the bit tick.
//     Gap counter counts bit ticks 0..GAP_BITS-1.
//   No combinational path from any input to tx, busy or done.
// TESTING (CLKS_PER_BIT=4, GAP_BITS=1, HEADER=8'hA5 unless noted)
//   1 Reset then idle 20 cycles: tx=1, busy=0, done=0 throughout.
//   2 send pulse with data=16'h1234: the line shows bytes A5, 34, 12. Each byte starts low
//     and the stop bit is high. Each bit lasts 4 cycles, with a 4-cycle high gap between
//     bytes. done pulses once, 128 cycles after tx first falls, and busy falls together
//     with done.
//   3 send re-asserted mid-frame with data=16'hFFFF: it is ignored. The frame still carries
//     34/12, and there is exactly one done.
//   4 send held high with data=16'h00FF: a second start bit falls in the cycle after done,
//     with no idle bit between frames. The second frame is A5, FF, 00.
//   5 rst_n pulsed low during the 2nd data bit of byte 1: tx=1 immediately and busy=0, with
//     no done. The next send of 16'hBEEF produces a complete clean frame A5, EF, BE.
//   6 GAP_BITS=0, data=16'h8001: the three bytes run contiguously, so a stop bit is
//     immediately followed by a start bit. done comes 120 cycles after the first fall.
//     Receiver model decodes 16'h8001.

Source files
------------

// File: rtl/pat_code_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pat_code_tx
//  Purpose  : Serial transmitter for the 16-bit pat code word. Sends one
//             header byte, then data[7:0], then data[15:8], each as an 8N1
//             UART byte (LSB first) on a single idle-high line. Optional
//             idle-high gap bit times are inserted between the bytes.
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset
//             send   - transmit request, sampled only while idle
//             data   - 16-bit code word, latched on acceptance
//             tx     - serial line (idle high)
//             busy   - high while a frame is in flight
//             done   - one-cycle pulse when the final stop bit completes
//  Revision : 1.0  initial release
// ============================================================================
module pat_code_tx #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         GAP_BITS     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [15:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  // Gap counter is kept at least one bit wide so GAP_BITS=0 still elaborates;
  // the GAP state is simply unreachable in that configuration.
  localparam int c_gap_w = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last =
    c_gap_w'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_baud_w-1:0]   r_baud_cnt;
  logic [c_gap_w-1:0]    r_gap_cnt;
  logic [2:0]            r_bit_idx;
  logic [1:0]            r_byte_idx;
  logic [7:0]            r_shift;
  logic [15:0]           r_hold;
  logic                  w_tick;
  logic [7:0]            w_next_byte;

  assign w_tick = (r_baud_cnt == c_baud_last);

  // Byte to load when leaving STOP: byte_idx still names the byte just sent.
  always_comb begin
    w_next_byte = r_hold[15:8];
    if (r_byte_idx == 2'd0) begin
      w_next_byte = r_hold[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_gap_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_hold     <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      // Baud counter free-runs only while a frame is in flight, so every
      // bit (start, data, stop, gap) lasts exactly CLKS_PER_BIT cycles.
      if (r_state == ST_IDLE || w_tick) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_byte_idx <= '0;
          r_bit_idx  <= '0;
          r_gap_cnt  <= '0;
          if (send) begin
            r_hold  <= data;
            r_shift <= HEADER;
            tx      <= 1'b0;
            busy    <= 1'b1;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_tick) begin
            tx        <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              tx      <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              tx        <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (w_tick) begin
            if (r_byte_idx == 2'd2) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_shift    <= w_next_byte;
              if (GAP_BITS > 0) begin
                r_gap_cnt <= '0;
                r_state   <= ST_GAP;
              end else begin
                tx      <= 1'b0;
                r_state <= ST_START;
              end
            end
          end
        end

        ST_GAP: begin
          if (w_tick) begin
            if (r_gap_cnt == c_gap_last) begin
              tx      <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
        end

        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
